// File: rtl/corescore_reset_seq.sv
// Reset sequencer for the core clock domain: qualifies MMCM lock, then releases the
// peripheral reset followed by the core-array reset, and re-sequences on lock loss.
module corescore_reset_seq #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned LOCK_CYCLES    = 16,
  parameter int unsigned HOLD_CYCLES    = 64,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned CW             = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_locked,
  output logic       o_rst_periph,
  output logic       o_rst_cores,
  output logic       o_ready,
  output logic [7:0] o_relock_cnt
);

  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StWaitLock = 3'd1,
    StHold     = 3'd2,
    StPeriph   = 3'd3,
    StRun      = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   rst_s;
  logic                   locked_s;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  relock_q, relock_d;
  logic        rst_periph_q, rst_periph_d;
  logic        rst_cores_q, rst_cores_d;
  logic        ready_q, ready_d;
  logic        lose;

  // Assert asynchronously, release synchronously by shifting a 1 through the chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], i_locked};
    end
  end

  assign rst_s    = rst_sync_q[SYNC_STAGES-1];
  assign locked_s = lock_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    relock_d = relock_q;
    lose     = 1'b0;
    case (state_q)
      StReset: begin
        if (rst_s) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (!locked_s) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StHold: begin
        if (!locked_s) begin
          lose = 1'b1;
        end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = StPeriph;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StPeriph: begin
        if (!locked_s) begin
          lose = 1'b1;
        end else if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StRun: begin
        if (!locked_s) lose = 1'b1;
      end
      default: state_d = StReset;
    endcase

    if (lose) begin
      state_d = StWaitLock;
      if (relock_q != 8'hff) relock_d = relock_q + 8'd1;
    end
    if (state_d != state_q) cnt_d = '0;

    // Outputs are derived from the next state so they move on the transition edge.
    rst_periph_d = !((state_d == StPeriph) || (state_d == StRun));
    rst_cores_d  = (state_d != StRun);
    ready_d      = (state_d == StRun);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StReset;
      cnt_q        <= '0;
      relock_q     <= '0;
      rst_periph_q <= 1'b1;
      rst_cores_q  <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      relock_q     <= relock_d;
      rst_periph_q <= rst_periph_d;
      rst_cores_q  <= rst_cores_d;
      ready_q      <= ready_d;
    end
  end

  assign o_rst_periph = rst_periph_q;
  assign o_rst_cores  = rst_cores_q;
  assign o_ready      = ready_q;
  assign o_relock_cnt = relock_q;

endmodule

// File: doc/corescore_reset_seq.md
Name: corescore_reset_seq

Overview:
- Reset sequencer directly downstream of the board clock generator.
- Runs in the generated core clock domain and takes the clock generator's lock indication plus an external asynchronous active-low reset.
- Produces glitch-free, staggered synchronous resets: peripherals (emitter/UART, arbiter) are released first, then the core array.
- Re-sequences automatically if lock is lost.

Parameters:
- SYNC_STAGES, 2: flop depth of the reset-release and lock synchronizers (min 2).
- LOCK_CYCLES, 16: consecutive synchronized lock-high samples required before sequencing continues (min 1).
- HOLD_CYCLES, 64: cycles both resets stay asserted after lock is qualified (min 1).
- STAGGER_CYCLES, 16: cycles between peripheral release and core release (min 1).
- CW, 16: internal counter width; must hold max(LOCK_CYCLES, HOLD_CYCLES, STAGGER_CYCLES).

Ports:
- i_clk, input, 1: generated core clock.
- i_rst_n, input, 1: asynchronous active-low reset. Asserted clears all state immediately.
- i_locked, input, 1: MMCM lock level, asynchronous to i_clk.
- o_rst_periph, output, 1: active-high synchronous reset for peripherals.
- o_rst_cores, output, 1: active-high synchronous reset for the core array.
- o_ready, output, 1: high once both resets are released.
- o_relock_cnt, output, 8: saturating count of lock-loss events.

Behaviour:
- Reset scheme (already decided): one clock, i_clk; reset i_rst_n is asynchronous, active-low.
- While i_rst_n=0, asynchronously and immediately:
  - state=RESET, all counters 0.
  - o_rst_periph=1, o_rst_cores=1, o_ready=0, o_relock_cnt=0.
  - Reset synchronizer chain cleared to 0.
- Release of i_rst_n:
  - Shifts a 1 through the SYNC_STAGES-deep chain; rst_s goes high SYNC_STAGES edges after release.
  - Assert is asynchronous; deassert is synchronous.
- i_locked passes through its own SYNC_STAGES chain (locked_s), which is also cleared by i_rst_n.
- All outputs are registered and change on the same edge as the state transition that implies them.
- State machine (one counter, cleared on every state change):
  - RESET: on the edge where rst_s=1, go to WAIT_LOCK.
  - WAIT_LOCK: counter increments while locked_s=1 and clears to 0 while locked_s=0. On the edge that samples the LOCK_CYCLES-th consecutive high, go to HOLD.
  - HOLD: both resets asserted; counter increments each edge. On the HOLD_CYCLES-th edge, go to PERIPH and set o_rst_periph=0.
  - PERIPH: counter increments. On the STAGGER_CYCLES-th edge, go to RUN, set o_rst_cores=0 and o_ready=1.
  - RUN: hold until lock loss.
- Lock loss (locked_s=0 sampled in HOLD, PERIPH or RUN):
  - Next edge: go to WAIT_LOCK, o_rst_periph=1, o_rst_cores=1, o_ready=0, counter=0.
  - o_relock_cnt increments, saturating at 255.
  - A locked_s drop in WAIT_LOCK only clears the counter; it does not count as an event.
- Timing with i_locked steady high, E0 = edge entering WAIT_LOCK, defaults:
  - HOLD entered at E0+16.
  - o_rst_periph falls at E0+80.
  - o_rst_cores falls and o_ready rises at E0+96.
- Invariants:
  - o_rst_cores=0 implies o_rst_periph=0.
  - o_ready == !o_rst_cores at all times.
- i_rst_n asserted mid-sequence or in RUN: immediate asynchronous return to the full reset values above, including o_relock_cnt=0.
- i_locked toggling faster than LOCK_CYCLES: the sequencer never leaves WAIT_LOCK and outputs stay in reset.
- Unused state encodings recover to RESET behaviour (resets asserted) on the next edge.

Test Plan:
- Power-up: i_rst_n low 5 cycles, i_locked=1 throughout, release. Expect rst_s high after 2 edges, o_rst_periph fall at E0+80, o_rst_cores/o_ready change at E0+96, o_relock_cnt=0.
- Lock delayed: i_locked rises 40 cycles after reset release. Expect HOLD entry exactly 16 edges after locked_s first goes high; outputs asserted until then.
- Lock glitching: i_locked high 10 cycles, low 1 cycle, repeated 20 times. Expect state never leaves WAIT_LOCK, both resets held 1, o_relock_cnt=0.
- Lock loss in RUN: drop i_locked for 3 cycles. Expect both resets reasserted and o_ready=0 one edge after locked_s falls, o_relock_cnt=1, then a full re-sequence: 16+64 to periph release, +16 to core release.
- Async reset mid-HOLD: pull i_rst_n low between clock edges. Expect outputs forced to reset values before the next edge and o_relock_cnt cleared. Then re-run the power-up timing.
- Saturation: force 260 lock-loss events from RUN. Expect o_relock_cnt=255 with no wrap.
